// File: rtl/gobou_fc_top.sv
// Dense-layer accelerator: GOBOU_CORE PEs, each with a private weight RAM, streaming inputs from and
// writing outputs to a shared image RAM. Define GOBOU_RELU_EN to clamp results at zero.
module gobou_fc_top #(
  parameter int DWIDTH        = 16,
  parameter int FL            = 8,
  parameter int IMGSIZE       = 12,
  parameter int GOBOU_CORE    = 4,
  parameter int GOBOU_CORELOG = 2,
  parameter int GOBOU_NETSIZE = 11,
  parameter int LWIDTH        = 10
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     req,
  input  logic [GOBOU_CORELOG-1:0] net_sel,
  input  logic                     net_we,
  input  logic [GOBOU_NETSIZE-1:0] net_addr,
  input  logic signed [DWIDTH-1:0] net_wdata,
  input  logic [IMGSIZE-1:0]       in_offset,
  input  logic [IMGSIZE-1:0]       out_offset,
  input  logic [GOBOU_NETSIZE-1:0] net_offset,
  input  logic [LWIDTH-1:0]        total_out,
  input  logic [LWIDTH-1:0]        total_in,
  input  logic signed [DWIDTH-1:0] img_rdata,
  output logic                     ack,
  output logic                     img_we,
  output logic [IMGSIZE-1:0]       img_addr,
  output logic signed [DWIDTH-1:0] img_wdata
);

  localparam int AW     = 2*DWIDTH + LWIDTH;
  localparam int OW     = LWIDTH + 1;
  localparam int NWORDS = 1 << GOBOU_NETSIZE;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_BIAS, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic                     ack_q, ack_d;
  logic                     img_we_q, img_we_d;
  logic [IMGSIZE-1:0]       img_addr_q, img_addr_d;
  logic signed [DWIDTH-1:0] img_wdata_q, img_wdata_d;
  logic [IMGSIZE-1:0]       in_off_q, in_off_d, out_off_q, out_off_d;
  logic [LWIDTH-1:0]        tin_q, tin_d, tout_q, tout_d;
  logic [GOBOU_NETSIZE-1:0] wbase_q, wbase_d, waddr_q, waddr_d;
  logic [LWIDTH-1:0]        cnt_q, cnt_d;
  logic [OW-1:0]            obase_q, obase_d, o_idx;
  logic                     v1_q, v1_d, v2_q;
  logic                     acc_clr, res_ld;
  logic [GOBOU_NETSIZE-1:0] mem_addr;

  logic signed [AW-1:0]     acc_q [GOBOU_CORE];
  logic signed [DWIDTH-1:0] res_q [GOBOU_CORE];
  logic signed [DWIDTH-1:0] wrd_q [GOBOU_CORE];
  logic signed [DWIDTH-1:0] wmem  [GOBOU_CORE][NWORDS];

  function automatic logic signed [AW-1:0] mac_ext(input logic signed [DWIDTH-1:0] x,
                                                   input logic signed [DWIDTH-1:0] w);
    logic signed [2*DWIDTH-1:0] p;
    p = x * w;
    return {{(AW-2*DWIDTH){p[2*DWIDTH-1]}}, p};
  endfunction

  function automatic logic signed [DWIDTH-1:0] post(input logic signed [AW-1:0] acc,
                                                    input logic signed [DWIDTH-1:0] b);
    logic signed [AW-1:0]     sh;
    logic signed [AW:0]       s;
    logic signed [DWIDTH-1:0] r;
    sh = acc >>> FL;
    s  = {sh[AW-1], sh} + {{(AW+1-DWIDTH){b[DWIDTH-1]}}, b};
    // In range only when every bit above the result's sign bit matches it
    if (s[AW:DWIDTH-1] == '0 || s[AW:DWIDTH-1] == '1) r = s[DWIDTH-1:0];
    else if (s[AW])                                   r = {1'b1, {(DWIDTH-1){1'b0}}};
    else                                              r = {1'b0, {(DWIDTH-1){1'b1}}};
`ifdef GOBOU_RELU_EN
    if (r[DWIDTH-1]) r = '0;
`endif
    return r;
  endfunction

  // The host owns the weight RAM port while idle; the engine owns it while busy
  assign mem_addr = ack_q ? net_addr : waddr_q;
  assign o_idx    = obase_q + OW'(cnt_q);

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < GOBOU_CORE; p++) begin
      if (ack_q && net_we && (net_sel == GOBOU_CORELOG'(p))) wmem[p][mem_addr] <= net_wdata;
      wrd_q[p] <= wmem[p][mem_addr];
    end
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    img_we_d    = 1'b0;
    img_addr_d  = img_addr_q;
    img_wdata_d = img_wdata_q;
    in_off_d    = in_off_q;
    out_off_d   = out_off_q;
    tin_d       = tin_q;
    tout_d      = tout_q;
    wbase_d     = wbase_q;
    waddr_d     = waddr_q;
    cnt_d       = cnt_q;
    obase_d     = obase_q;
    v1_d        = 1'b0;
    acc_clr     = 1'b0;
    res_ld      = 1'b0;
    case (state_q)
      S_IDLE: begin
        ack_d = 1'b1;
        if (ack_q && req) begin
          ack_d     = 1'b0;
          state_d   = S_MAC;
          in_off_d  = in_offset;
          out_off_d = out_offset;
          tin_d     = total_in;
          tout_d    = total_out;
          wbase_d   = net_offset;
          cnt_d     = '0;
          obase_d   = '0;
          acc_clr   = 1'b1;
        end
      end
      S_MAC: begin
        img_addr_d = in_off_q + IMGSIZE'(cnt_q);
        waddr_d    = wbase_q + GOBOU_NETSIZE'(cnt_q);
        v1_d       = 1'b1;
        if (cnt_q == tin_q - LWIDTH'(1)) begin
          cnt_d   = '0;
          state_d = S_BIAS;
        end else begin
          cnt_d = cnt_q + LWIDTH'(1);
        end
      end
      // Bias address issued on the first cycle; by the third both the bias word and the
      // final product (two-stage read pipeline) have landed
      S_BIAS: begin
        if (cnt_q == '0) waddr_d = wbase_q + GOBOU_NETSIZE'(tin_q);
        if (cnt_q == LWIDTH'(2)) begin
          res_ld  = 1'b1;
          cnt_d   = '0;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + LWIDTH'(1);
        end
      end
      S_OUT: begin
        img_we_d    = (o_idx < OW'(tout_q));
        img_addr_d  = out_off_q + IMGSIZE'(o_idx);
        img_wdata_d = res_q[cnt_q[GOBOU_CORELOG-1:0]];
        if (cnt_q == LWIDTH'(GOBOU_CORE-1)) begin
          cnt_d = '0;
          if (obase_q + OW'(GOBOU_CORE) >= OW'(tout_q)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_MAC;
            obase_d = obase_q + OW'(GOBOU_CORE);
            wbase_d = wbase_q + GOBOU_NETSIZE'(tin_q) + GOBOU_NETSIZE'(1);
            acc_clr = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + LWIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b1;
      img_we_q    <= 1'b0;
      img_addr_q  <= '0;
      img_wdata_q <= '0;
      in_off_q    <= '0;
      out_off_q   <= '0;
      tin_q       <= '0;
      tout_q      <= '0;
      wbase_q     <= '0;
      waddr_q     <= '0;
      cnt_q       <= '0;
      obase_q     <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      for (int unsigned p = 0; p < GOBOU_CORE; p++) begin
        acc_q[p] <= '0;
        res_q[p] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      img_we_q    <= img_we_d;
      img_addr_q  <= img_addr_d;
      img_wdata_q <= img_wdata_d;
      in_off_q    <= in_off_d;
      out_off_q   <= out_off_d;
      tin_q       <= tin_d;
      tout_q      <= tout_d;
      wbase_q     <= wbase_d;
      waddr_q     <= waddr_d;
      cnt_q       <= cnt_d;
      obase_q     <= obase_d;
      v1_q        <= v1_d;
      v2_q        <= v1_q;
      for (int unsigned p = 0; p < GOBOU_CORE; p++) begin
        if (acc_clr)   acc_q[p] <= '0;
        else if (v2_q) acc_q[p] <= acc_q[p] + mac_ext(img_rdata, wrd_q[p]);
        if (res_ld)    res_q[p] <= post(acc_q[p], wrd_q[p]);
      end
    end
  end

  assign ack       = ack_q;
  assign img_we    = img_we_q;
  assign img_addr  = img_addr_q;
  assign img_wdata = img_wdata_q;

endmodule

// File: tb/tb_gobou_fc_top.sv
// Bench for gobou_fc_top: directed vector table, randomized runs against an arithmetic reference,
// a larger layer, and reset during a run. Honours GOBOU_RELU_EN like the design.
module tb_gobou_fc_top;

`ifdef GOBOU_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        xrst, req, net_we, ack, img_we;
  logic [1:0]  net_sel;
  logic [10:0] net_addr, net_offset;
  logic [15:0] net_wdata, img_rdata, img_wdata;
  logic [11:0] in_offset, out_offset, img_addr;
  logic [9:0]  total_out, total_in;

  logic        h_we;
  logic [11:0] h_addr;
  logic [15:0] h_data;
  logic [15:0] imem [4096];
  logic [15:0] eimg [4096];
  logic [15:0] wref [4][2048];

  int checks = 0;
  int errors = 0;
  int r_in, r_out, r_noff, r_tin, r_tout;

  typedef struct {
    int          tin;
    int          tout;
    logic [15:0] x0, x1, w, b, e_relu, e_raw;
  } vec_t;
  vec_t vecs [8];

  gobou_fc_top #(.DWIDTH(16), .FL(8), .IMGSIZE(12), .GOBOU_CORE(4), .GOBOU_CORELOG(2),
                 .GOBOU_NETSIZE(11), .LWIDTH(10)) dut (
    .clk(clk), .xrst(xrst), .req(req), .net_sel(net_sel), .net_we(net_we), .net_addr(net_addr),
    .net_wdata(net_wdata), .in_offset(in_offset), .out_offset(out_offset), .net_offset(net_offset),
    .total_out(total_out), .total_in(total_in), .img_rdata(img_rdata), .ack(ack), .img_we(img_we),
    .img_addr(img_addr), .img_wdata(img_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (img_we)    imem[img_addr] <= img_wdata;
    else if (h_we) imem[h_addr] <= h_data;
    img_rdata <= imem[img_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic put_img(input int a, input logic [15:0] d);
    h_addr = 12'(a % 4096); h_data = d; h_we = 1'b1;
    eimg[a % 4096] = d;
    @(negedge clk);
    h_we = 1'b0;
  endtask

  task automatic put_w(input int pe, input int a, input logic [15:0] d);
    net_sel = 2'(pe); net_addr = 11'(a % 2048); net_wdata = d; net_we = 1'b1;
    wref[pe][a % 2048] = d;
    @(negedge clk);
    net_we = 1'b0;
  endtask

  function automatic int ngroups();
    return (r_tout + 3) / 4;
  endfunction

  function automatic logic [15:0] ref_out(input int o);
    longint s = 0;
    int g = o / 4;
    int dn = o % 4;
    int base = r_noff + g * (r_tin + 1);
    for (int i = 0; i < r_tin; i++)
      s += longint'($signed(eimg[(r_in + i) % 4096])) * longint'($signed(wref[dn][(base + i) % 2048]));
    s = (s >>> 8) + longint'($signed(wref[dn][(base + r_tin) % 2048]));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (RELU && s < 0) s = 0;
    return 16'(s);
  endfunction

  task automatic prep_region();
    for (int k = 0; k < ngroups() * 4 + 2; k++) put_img(r_out + k, 16'h5A5A);
  endtask

  task automatic check_region(input string tag);
    for (int k = 0; k < ngroups() * 4 + 2; k++)
      chk($sformatf("%s_o%0d", tag, k), 32'(imem[(r_out + k) % 4096]), 32'(eimg[(r_out + k) % 4096]));
  endtask

  // Start a run, then disturb every control input while busy; none of it may take effect
  task automatic do_run(input string tag);
    int cyc = 0;
    in_offset = 12'(r_in); out_offset = 12'(r_out); net_offset = 11'(r_noff);
    total_in = 10'(r_tin); total_out = 10'(r_tout); req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk({tag, "_ack_drop"}, 32'(ack), 32'd0);
    in_offset = 12'($urandom); out_offset = 12'($urandom); net_offset = 11'($urandom);
    total_in = 10'($urandom); total_out = 10'($urandom); req = 1'b1;
    net_sel = 2'd0; net_addr = 11'((r_noff + (ngroups() - 1) * (r_tin + 1) + r_tin) % 2048);
    net_wdata = 16'h1234; net_we = 1'b1;
    @(negedge clk);
    req = 1'b0; net_we = 1'b0;
    while (ack !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_in_time"}, 32'(cyc < 20000), 32'd1);
    chk({tag, "_we_idle"}, 32'(img_we), 32'd0);
  endtask

  initial begin
    vecs[0] = '{2, 4, 16'h0100, 16'h0200, 16'h0100, 16'h0080, 16'h0380, 16'h0380};
    vecs[1] = '{2, 4, 16'h0100, 16'h0200, 16'hFF00, 16'h0000, 16'h0000, 16'hFD00};
    vecs[2] = '{2, 5, 16'h0100, 16'h0200, 16'h0100, 16'h0080, 16'h0380, 16'h0380};
    vecs[3] = '{4, 4, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF};
    vecs[4] = '{4, 3, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h8000};
    vecs[5] = '{1, 1, 16'h0300, 16'h0300, 16'h0200, 16'hFF00, 16'h0500, 16'h0500};
    vecs[6] = '{1, 2, 16'h0001, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[7] = '{1, 4, 16'h7F00, 16'h7F00, 16'h0100, 16'h0200, 16'h7FFF, 16'h7FFF};

    xrst = 1'b1; req = 1'b0; net_we = 1'b0; net_sel = '0; net_addr = '0; net_wdata = '0;
    in_offset = '0; out_offset = '0; net_offset = '0; total_in = 10'd1; total_out = 10'd1;
    h_we = 1'b0; h_addr = '0; h_data = '0;
    @(negedge clk);
    xrst = 1'b0;
    chk("rst_ack", 32'(ack), 32'd1);
    chk("rst_we", 32'(img_we), 32'd0);
    chk("rst_addr", 32'(img_addr), 32'd0);
    chk("rst_wdata", 32'(img_wdata), 32'd0);

    for (int v = 0; v < 8; v++) begin
      r_tin = vecs[v].tin; r_tout = vecs[v].tout;
      r_in = 16; r_out = 256; r_noff = (v % 2 == 1) ? 2045 : 0;
      for (int i = 0; i < r_tin; i++) put_img(r_in + i, (i % 2 == 0) ? vecs[v].x0 : vecs[v].x1);
      for (int g = 0; g < ngroups(); g++)
        for (int dn = 0; dn < 4; dn++)
          for (int i = 0; i <= r_tin; i++)
            put_w(dn, r_noff + g * (r_tin + 1) + i, (i == r_tin) ? vecs[v].b : vecs[v].w);
      prep_region();
      do_run($sformatf("vec%0d", v));
      for (int o = 0; o < r_tout; o++) eimg[r_out + o] = RELU ? vecs[v].e_relu : vecs[v].e_raw;
      check_region($sformatf("vec%0d", v));
    end

    for (int it = 0; it < 8; it++) begin
      r_tin = $urandom_range(1, 20); r_tout = $urandom_range(1, 13);
      r_in = (it == 0) ? 4090 : $urandom_range(0, 4095);
      r_noff = (it == 0) ? 2040 : $urandom_range(0, 2047);
      r_out = (r_in + 2048) % 4096;
      for (int i = 0; i < r_tin; i++) put_img(r_in + i, 16'(int'($urandom_range(0, 2047)) - 1024));
      for (int g = 0; g < ngroups(); g++)
        for (int dn = 0; dn < 4; dn++)
          for (int i = 0; i <= r_tin; i++)
            put_w(dn, r_noff + g * (r_tin + 1) + i,
                  (i == r_tin) ? 16'($urandom) : 16'(int'($urandom_range(0, 1023)) - 512));
      prep_region();
      do_run($sformatf("rnd%0d", it));
      for (int o = 0; o < r_tout; o++) eimg[(r_out + o) % 4096] = ref_out(o);
      check_region($sformatf("rnd%0d", it));
    end

    r_tin = 100; r_tout = 70; r_in = 0; r_out = 1000; r_noff = 100;
    for (int i = 0; i < r_tin; i++) put_img(r_in + i, 16'(int'($urandom_range(0, 1023)) - 512));
    for (int g = 0; g < ngroups(); g++)
      for (int dn = 0; dn < 4; dn++)
        for (int i = 0; i <= r_tin; i++)
          put_w(dn, r_noff + g * (r_tin + 1) + i,
                (i == r_tin) ? 16'(int'($urandom_range(0, 4095)) - 2048)
                             : 16'(int'($urandom_range(0, 511)) - 256));
    prep_region();
    do_run("big");
    for (int o = 0; o < r_tout; o++) eimg[r_out + o] = ref_out(o);
    check_region("big");

    begin
      int wcnt = 0;
      in_offset = 12'(r_in); out_offset = 12'(r_out); net_offset = 11'(r_noff);
      total_in = 10'(r_tin); total_out = 10'(r_tout); req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (150) @(negedge clk);
      xrst = 1'b1;
      @(negedge clk);
      xrst = 1'b0;
      chk("midrst_ack", 32'(ack), 32'd1);
      chk("midrst_we", 32'(img_we), 32'd0);
      repeat (300) begin
        @(negedge clk);
        if (img_we === 1'b1) wcnt++;
      end
      chk("midrst_no_writes", 32'(wcnt), 32'd0);
      chk("midrst_ack_hold", 32'(ack), 32'd1);
    end

    // Weights written before the reset must still be in place
    r_tout = 8; r_out = 2000;
    prep_region();
    do_run("post_rst");
    for (int o = 0; o < r_tout; o++) eimg[r_out + o] = ref_out(o);
    check_region("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
